// File: rtl/teng_rx_decode_sm.sv
// teng_rx_decode_sm
// 10GBASE-R receive decoder. It classifies each 66-bit block, runs the receive
// state machine with a one-block lookahead, and drives XGMII lanes.
//
// Ports:
//   clk_i, rst_n          block clock, synchronous active-low reset
//   decode_data_i/_head_i block payload (bit 0 first on the line) and sync header
//   decode_data_vld_i     payload/header valid; the pipeline only advances on it
//   block_lock_i          block-lock level; low forces RX_INIT and flushes lookahead
//   err_cnt_clr_i         synchronous clear of err_cnt_o (wins over increment)
//   xgmii_rxd_o/_rxc_o    decoded XGMII data/control, lane 0 in the low byte
//   xgmii_vld_o           one-cycle strobe qualifying rxd/rxc
//   decode_error_o        strobed with any block emitted as an error block
//   err_cnt_o             saturating count of error blocks
//
// Build option: define TENG_RX_DESCRAMBLE_EN to pass the payload through the
// x^58+x^39+1 self-synchronous descrambler before decoding. Ports and latency
// do not change.
module teng_rx_decode_sm #(
    parameter int ERR_CNT_W    = 16,
    parameter bit LF_ON_UNLOCK = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [63:0]          decode_data_i,
    input  logic [1:0]           decode_head_i,
    input  logic                 decode_data_vld_i,
    input  logic                 block_lock_i,
    input  logic                 err_cnt_clr_i,
    output logic [63:0]          xgmii_rxd_o,
    output logic [7:0]           xgmii_rxc_o,
    output logic                 xgmii_vld_o,
    output logic                 decode_error_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [63:0] IDLE_RXD = 64'h07070707_07070707;
    localparam logic [63:0] ERR_RXD  = 64'hFEFEFEFE_FEFEFEFE;
    localparam logic [63:0] LF_RXD   = 64'h0100009C_0100009C;

    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_cls_t;

    rx_state_t   state;
    logic        la_vld;
    logic [63:0] la_data;
    blk_cls_t    la_cls;

    logic [63:0] pay;
    blk_cls_t    in_cls;
    rx_state_t   nxt_state;
    logic [71:0] dec;
    logic        err_inc;

    // ------------------------------------------------------------------
    // Optional descrambler. Shift register holds previously received
    // scrambled bits, bit 0 the most recent.
    // ------------------------------------------------------------------
`ifdef TENG_RX_DESCRAMBLE_EN
    logic [57:0] scr_q;
    logic [57:0] scr_d;

    always_comb begin
        scr_d = scr_q;
        pay   = '0;
        for (int i = 0; i < 64; i++) begin
            pay[i] = decode_data_i[i] ^ scr_d[38] ^ scr_d[57];
            scr_d  = {scr_d[56:0], decode_data_i[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n)
            scr_q <= '0;
        else if (decode_data_vld_i)
            scr_q <= scr_d;
    end
`else
    assign pay = decode_data_i;
`endif

    // ------------------------------------------------------------------
    // Block helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] code_map(input logic [6:0] c);
        return (c == 7'h00) ? 8'h07 : 8'hFE;
    endfunction

    function automatic blk_cls_t classify(input logic [1:0] head, input logic [63:0] d);
        blk_cls_t c;
        logic     codes_ok;
        codes_ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (d[8+7*i +: 7] != 7'h00 && d[8+7*i +: 7] != 7'h1e)
                codes_ok = 1'b0;
        c = BLK_E;
        if (head == 2'b10)
            c = BLK_D;
        else if (head == 2'b01) begin
            case (d[7:0])
                8'h1e:        if (codes_ok) c = BLK_C;
                8'h4b:        if (d[35:32] == 4'h0) c = BLK_C;
                8'h33, 8'h78: c = BLK_S;
                8'h87, 8'h99, 8'haa, 8'hb4,
                8'hcc, 8'hd2, 8'he1, 8'hff: c = BLK_T;
                default:      c = BLK_E;
            endcase
        end
        return c;
    endfunction

    // Returns {rxc, rxd}. Only called for C/S/D/T blocks; E blocks always
    // land in RX_E and are replaced by the error pattern.
    function automatic logic [71:0] decode(input blk_cls_t c, input logic [63:0] d);
        logic [63:0] rxd;
        logic [7:0]  rxc;
        logic [2:0]  k;
        rxd = IDLE_RXD;
        rxc = 8'hFF;
        k   = 3'd7;
        if (c == BLK_D) begin
            rxd = d;
            rxc = 8'h00;
        end else begin
            case (d[7:0])
                8'h1e: for (int i = 0; i < 8; i++) rxd[8*i +: 8] = code_map(d[8+7*i +: 7]);
                8'h4b: begin
                    rxd[31:0] = {d[31:8], 8'h9C};
                    rxc       = 8'hF1;
                end
                8'h78: begin
                    rxd = {d[63:8], 8'hFB};
                    rxc = 8'h01;
                end
                8'h33: begin
                    for (int i = 0; i < 4; i++) rxd[8*i +: 8] = code_map(d[8+7*i +: 7]);
                    rxd[63:32] = {d[63:40], 8'hFB};
                    rxc        = 8'h1F;
                end
                default: begin
                    // Terminate: k data bytes precede /T/; trailing code fields ignored.
                    case (d[7:0])
                        8'h87:   k = 3'd0;
                        8'h99:   k = 3'd1;
                        8'haa:   k = 3'd2;
                        8'hb4:   k = 3'd3;
                        8'hcc:   k = 3'd4;
                        8'hd2:   k = 3'd5;
                        8'he1:   k = 3'd6;
                        default: k = 3'd7;
                    endcase
                    for (int i = 0; i < 7; i++)
                        if (i < int'(k)) rxd[8*i +: 8] = d[8+8*i +: 8];
                    rxd[8*k +: 8] = 8'hFD;
                    rxc           = 8'hFF << k;
                end
            endcase
        end
        return {rxc, rxd};
    endfunction

    // nb is the class of the lookahead block; a T is only legal ahead of S or C.
    function automatic rx_state_t next_state(input rx_state_t s, input blk_cls_t c,
                                             input blk_cls_t nb);
        rx_state_t n;
        logic      t_ok;
        t_ok = (c == BLK_T) && (nb == BLK_S || nb == BLK_C);
        n    = RX_E;
        case (s)
            RX_D: begin
                if (c == BLK_D)  n = RX_D;
                else if (t_ok)   n = RX_T;
            end
            RX_E: begin
                if (c == BLK_D)      n = RX_D;
                else if (c == BLK_C) n = RX_C;
                else if (t_ok)       n = RX_T;
            end
            default: begin
                if (c == BLK_C)      n = RX_C;
                else if (c == BLK_S) n = RX_D;
            end
        endcase
        return n;
    endfunction

    always_comb begin
        in_cls    = classify(decode_head_i, pay);
        nxt_state = next_state(state, la_cls, in_cls);
        dec       = decode(la_cls, la_data);
        err_inc   = block_lock_i && decode_data_vld_i && la_vld && (nxt_state == RX_E);
    end

    // ------------------------------------------------------------------
    // State machine, lookahead register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state          <= RX_INIT;
            la_vld         <= 1'b0;
            la_data        <= '0;
            la_cls         <= BLK_E;
            xgmii_rxd_o    <= IDLE_RXD;
            xgmii_rxc_o    <= 8'hFF;
            xgmii_vld_o    <= 1'b0;
            decode_error_o <= 1'b0;
            err_cnt_o      <= '0;
        end else begin
            xgmii_vld_o    <= 1'b0;
            decode_error_o <= 1'b0;

            if (err_cnt_clr_i)
                err_cnt_o <= '0;
            else if (err_inc && err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + 1'b1;

            if (!block_lock_i) begin
                // Unlocked output is a status indication, not a decode error,
                // so it neither flags decode_error_o nor counts.
                state  <= RX_INIT;
                la_vld <= 1'b0;
                if (decode_data_vld_i) begin
                    xgmii_vld_o <= 1'b1;
                    xgmii_rxd_o <= LF_ON_UNLOCK ? LF_RXD : ERR_RXD;
                    xgmii_rxc_o <= LF_ON_UNLOCK ? 8'h11 : 8'hFF;
                end
            end else if (decode_data_vld_i) begin
                la_vld  <= 1'b1;
                la_data <= pay;
                la_cls  <= in_cls;
                if (la_vld) begin
                    state       <= nxt_state;
                    xgmii_vld_o <= 1'b1;
                    if (nxt_state == RX_E) begin
                        xgmii_rxd_o    <= ERR_RXD;
                        xgmii_rxc_o    <= 8'hFF;
                        decode_error_o <= 1'b1;
                    end else begin
                        {xgmii_rxc_o, xgmii_rxd_o} <= dec;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_teng_rx_decode_sm.sv
// Self-checking bench for teng_rx_decode_sm. Blocks are generated from their
// intended XGMII lane contents, so each block carries its own expected decode;
// the reference model only tracks framing legality and the lookahead delay.
module tb_teng_rx_decode_sm;

    localparam logic [63:0] IDLE_RXD = 64'h07070707_07070707;
    localparam logic [63:0] ERR_RXD  = 64'hFEFEFEFE_FEFEFEFE;
    localparam logic [63:0] LF_RXD   = 64'h0100009C_0100009C;

    localparam int CL_C = 0, CL_S = 1, CL_D = 2, CL_T = 3, CL_E = 4;
    localparam int ST_INIT = 0, ST_C = 1, ST_D = 2, ST_T = 3, ST_E = 4;

    typedef struct {
        logic [1:0]  head;
        logic [63:0] data;
        int          cls;
        logic [63:0] rxd;
        logic [7:0]  rxc;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] decode_data_i = '0;
    logic [1:0]  decode_head_i = 2'b01;
    logic        decode_data_vld_i = 1'b0;
    logic        block_lock_i = 1'b1;
    logic        err_cnt_clr_i = 1'b0;

    logic [63:0] rxd, rxd2;
    logic [7:0]  rxc, rxc2;
    logic        xvld, xvld2, derr, derr2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    teng_rx_decode_sm u_dut (
        .clk_i(clk), .rst_n(rst_n), .decode_data_i(decode_data_i), .decode_head_i(decode_head_i),
        .decode_data_vld_i(decode_data_vld_i), .block_lock_i(block_lock_i), .err_cnt_clr_i(err_cnt_clr_i),
        .xgmii_rxd_o(rxd), .xgmii_rxc_o(rxc), .xgmii_vld_o(xvld), .decode_error_o(derr), .err_cnt_o(cnt)
    );

    teng_rx_decode_sm #(.ERR_CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_n(rst_n), .decode_data_i(decode_data_i), .decode_head_i(decode_head_i),
        .decode_data_vld_i(decode_data_vld_i), .block_lock_i(block_lock_i), .err_cnt_clr_i(err_cnt_clr_i),
        .xgmii_rxd_o(rxd2), .xgmii_rxc_o(rxc2), .xgmii_vld_o(xvld2), .decode_error_o(derr2), .err_cnt_o(cnt2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Block generator. kind: 0 D, 1 random idle/error codes, 2 ordered set,
    // 3 S 0x78, 4 S 0x33, 5 T (arg = position or -1), 6 E (arg = variant
    // or -1), 7 pure idle.
    // ------------------------------------------------------------------
    function automatic blk_t gen(input int kind, input int arg);
        blk_t        b;
        logic [7:0]  ttype [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
        logic [7:0]  badt  [5] = '{8'h00, 8'h2d, 8'h55, 8'h66, 8'h4c};
        logic [6:0]  code;
        logic [55:0] r;
        int          k;
        b.head = 2'b01;
        b.data = {$urandom, $urandom};
        b.rxd  = IDLE_RXD;
        b.rxc  = 8'hFF;
        b.cls  = CL_E;
        r      = {$urandom, $urandom};
        case (kind)
            0: begin
                b.head = 2'b10; b.rxd = b.data; b.rxc = 8'h00; b.cls = CL_D;
            end
            1, 7: begin
                b.data = '0;
                b.data[7:0] = 8'h1e;
                for (int i = 0; i < 8; i++) begin
                    code = (kind == 1 && $urandom_range(0, 3) == 0) ? 7'h1e : 7'h00;
                    b.data[8+7*i +: 7] = code;
                    b.rxd[8*i +: 8]    = (code == 7'h00) ? 8'h07 : 8'hFE;
                end
                b.cls = CL_C;
            end
            2: begin
                b.data = {28'h0, 4'h0, r[23:0], 8'h4b};
                b.rxd  = {32'h07070707, r[23:0], 8'h9C};
                b.rxc  = 8'hF1; b.cls = CL_C;
            end
            3: begin
                b.data = {r, 8'h78}; b.rxd = {r, 8'hFB}; b.rxc = 8'h01; b.cls = CL_S;
            end
            4: begin
                b.data = {r[23:0], 4'h0, 28'h0, 8'h33};
                b.rxd  = {r[23:0], 8'hFB, 32'h07070707};
                b.rxc  = 8'h1F; b.cls = CL_S;
            end
            5: begin
                k = (arg < 0) ? int'($urandom_range(0, 7)) : arg;
                b.data[7:0] = ttype[k];
                for (int i = 0; i < 8; i++) begin
                    if (i < k)       b.rxd[8*i +: 8] = b.data[8+8*i +: 8];
                    else if (i == k) b.rxd[8*i +: 8] = 8'hFD;
                    else             b.rxd[8*i +: 8] = 8'h07;
                end
                b.rxc = 8'hFF << k;
                b.cls = CL_T;
            end
            default: begin
                k = (arg < 0) ? int'($urandom_range(0, 4)) : arg;
                case (k)
                    0: b.head = 2'b00;
                    1: b.head = 2'b11;
                    2: b.data[7:0] = badt[$urandom_range(0, 4)];
                    3: begin
                        b.data = '0; b.data[7:0] = 8'h1e;
                        b.data[8+7*$urandom_range(0, 7) +: 7] = 7'h2a;
                    end
                    default: begin
                        b.data[7:0]   = 8'h4b;
                        b.data[35:32] = 4'(1 + $urandom_range(0, 14));
                    end
                endcase
            end
        endcase
        return b;
    endfunction

    function automatic blk_t gen_rand();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)  return gen(0, 0);
        if (r == 3) return gen(1, 0);
        if (r == 4) return gen($urandom_range(0, 1) == 0 ? 2 : 7, 0);
        if (r == 5) return gen(3, 0);
        if (r == 6) return gen(4, 0);
        if (r < 9)  return gen(5, -1);
        return gen(6, -1);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: legality table indexed [state][class], where class 3
    // means a T followed by S/C and an unfollowed T counts as class E.
    // ------------------------------------------------------------------
    int   nxt_tbl [5][5];
    int   m_state;
    logic m_have;
    blk_t m_buf;
    int   m_cnt, m_cnt2;

    task automatic apply(input logic rst, input logic vld, input logic lock,
                         input logic clr, input blk_t b);
        logic        e_vld, e_err, e_rst, inc;
        logic [63:0] e_rxd;
        logic [7:0]  e_rxc;
        int          ec;
        rst_n = !rst; decode_data_vld_i = vld; block_lock_i = lock;
        err_cnt_clr_i = clr; decode_head_i = b.head; decode_data_i = b.data;
        e_vld = 1'b0; e_err = 1'b0; e_rst = rst; inc = 1'b0;
        e_rxd = IDLE_RXD; e_rxc = 8'hFF;
        if (rst) begin
            m_state = ST_INIT; m_have = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (!lock) begin
                m_state = ST_INIT; m_have = 1'b0;
                if (vld) begin e_vld = 1'b1; e_rxd = LF_RXD; e_rxc = 8'h11; end
            end else if (vld) begin
                if (m_have) begin
                    ec = m_buf.cls;
                    if (ec == CL_T && !(b.cls == CL_C || b.cls == CL_S)) ec = CL_E;
                    m_state = nxt_tbl[m_state][ec];
                    e_vld = 1'b1;
                    if (m_state == ST_E) begin
                        e_rxd = ERR_RXD; e_rxc = 8'hFF; e_err = 1'b1; inc = 1'b1;
                    end else begin
                        e_rxd = m_buf.rxd; e_rxc = m_buf.rxc;
                    end
                end
                m_buf = b; m_have = 1'b1;
            end
            if (clr) begin m_cnt = 0; m_cnt2 = 0; end
            else if (inc) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end

        @(posedge clk);
        #1;
        if (e_rst) begin
            chk("rst_rxd", rxd, IDLE_RXD);
            chk("rst_rxc", {56'h0, rxc}, 64'hFF);
            chk("rst_vld", {63'h0, xvld}, 64'h0);
            chk("rst_err", {63'h0, derr}, 64'h0);
            chk("rst_cnt", {48'h0, cnt}, 64'h0);
            chk("rst_cnt2", {62'h0, cnt2}, 64'h0);
        end else begin
            chk("vld", {63'h0, xvld}, {63'h0, e_vld});
            chk("vld2", {63'h0, xvld2}, {63'h0, e_vld});
            if (e_vld) begin
                chk("rxd", rxd, e_rxd);
                chk("rxc", {56'h0, rxc}, {56'h0, e_rxc});
                chk("dec_err", {63'h0, derr}, {63'h0, e_err});
                chk("rxd2", rxd2 ^ {56'h0, rxc2} ^ {63'h0, derr2},
                    e_rxd ^ {56'h0, e_rxc} ^ {63'h0, e_err});
            end
            chk("err_cnt", {48'h0, cnt}, 64'(m_cnt));
            chk("err_cnt_sat", {62'h0, cnt2}, 64'(m_cnt2));
        end
    endtask

    task automatic send(input blk_t b);
        apply(1'b0, 1'b1, 1'b1, 1'b0, b);
    endtask

    initial begin
        logic v, l, c;
        int   r;
        nxt_tbl[ST_INIT] = '{ST_C, ST_D, ST_E, ST_E, ST_E};
        nxt_tbl[ST_C]    = '{ST_C, ST_D, ST_E, ST_E, ST_E};
        nxt_tbl[ST_T]    = '{ST_C, ST_D, ST_E, ST_E, ST_E};
        nxt_tbl[ST_D]    = '{ST_E, ST_E, ST_D, ST_T, ST_E};
        nxt_tbl[ST_E]    = '{ST_C, ST_E, ST_D, ST_T, ST_E};

        repeat (3) apply(1'b1, 1'b0, 1'b1, 1'b0, gen(7, 0));

        // idle x3 (plus one to push the third out)
        repeat (4) send(gen(7, 0));
        // S D D T0 C C: clean frame
        send(gen(3, 0)); send(gen(0, 0)); send(gen(0, 0));
        send(gen(5, 0)); send(gen(7, 0)); send(gen(7, 0));
        // T not followed by S/C
        send(gen(3, 0)); send(gen(0, 0)); send(gen(5, 1)); send(gen(0, 0));
        send(gen(5, 3)); send(gen(7, 0)); send(gen(7, 0));
        // bad header inside idle, then recovery
        send(gen(7, 0)); send(gen(6, 0)); send(gen(7, 0)); send(gen(7, 0));
        // saturation, then clear coincident with an error block
        repeat (5) send(gen(6, 0));
        apply(1'b0, 1'b1, 1'b1, 1'b1, gen(6, 0));
        send(gen(6, 1)); send(gen(7, 0)); send(gen(7, 0));
        // lock drop mid-frame, relock with S
        send(gen(3, 0)); send(gen(0, 0));
        apply(1'b0, 1'b1, 1'b0, 1'b0, gen(0, 0));
        apply(1'b0, 1'b0, 1'b0, 1'b0, gen(0, 0));
        apply(1'b0, 1'b1, 1'b0, 1'b0, gen(0, 0));
        send(gen(3, 0)); send(gen(0, 0)); send(gen(5, 4)); send(gen(2, 0)); send(gen(7, 0));
        // reset mid-frame discards the buffered block
        send(gen(4, 0)); send(gen(0, 0));
        repeat (2) apply(1'b1, 1'b1, 1'b1, 1'b0, gen(0, 0));
        send(gen(7, 0)); send(gen(7, 0));

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                apply(1'b1, 1'b0, 1'b1, 1'b0, gen(7, 0));
            end else begin
                v = ($urandom_range(0, 9) < 8);
                l = ($urandom_range(0, 49) != 0);
                c = ($urandom_range(0, 39) == 0);
                apply(1'b0, v, l, c, gen_rand());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
